// File: rtl/stage2_check_sum_ctrl_if.sv
// Record-in / checksum-out bundle between the stage-2 field extractor and the packet-check stage.
// Latency/backpressure are set by the engine; this file only groups the valid/ready handshake signals.
// master = extractor + packet-check side, slave = checksum engine; STAGE2_CHECK_SUM_CMP_EN adds compare ports.
interface stage2_check_sum_ctrl_if #(
  parameter int CSUM_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       block_size_data;
  logic [31:0]       seq_number_data;
  logic [7:0]        message_number_data;
  logic [63:0]       time_message_data;
  logic [279:0]      message_1;
  logic [279:0]      message_2;
  logic [279:0]      message_3;
  logic [2:0]        msg_cnt;
  logic              out_valid;
  logic              out_ready;
  logic [CSUM_W-1:0] check_sum_data;
  logic              cnt_err;
`ifdef STAGE2_CHECK_SUM_CMP_EN
  logic [CSUM_W-1:0] exp_check_sum;
  logic              check_sum_ok;
`endif

  modport master (
    output in_valid, block_size_data, seq_number_data, message_number_data,
           time_message_data, message_1, message_2, message_3, msg_cnt, out_ready,
`ifdef STAGE2_CHECK_SUM_CMP_EN
    output exp_check_sum,
    input  check_sum_ok,
`endif
    input  in_ready, out_valid, check_sum_data, cnt_err
  );

  modport slave (
    input  in_valid, block_size_data, seq_number_data, message_number_data,
           time_message_data, message_1, message_2, message_3, msg_cnt, out_ready,
`ifdef STAGE2_CHECK_SUM_CMP_EN
    input  exp_check_sum,
    output check_sum_ok,
`endif
    output in_ready, out_valid, check_sum_data, cnt_err
  );
endinterface

// File: rtl/stage2_check_sum_ctrl.sv
// Sequential byte-sum checksum over a captured stage-2 record, LANE_BYTES bytes per cycle (macro STAGE2_CHECK_SUM_CMP_EN adds expected-sum compare).
// Latency: handshake in cycle T -> out_valid in cycle T+1+ceil(N/LANE_BYTES), N = 15 + 35*min(msg_cnt,3).
// Backpressure: result held stable while out_ready=0; in_ready stays 0 from capture until the result is taken.
module stage2_check_sum_ctrl #(
  parameter int LANE_BYTES = 8,
  parameter int CSUM_W     = 8
) (
  input logic                    clk,
  input logic                    rst,
  stage2_check_sum_ctrl_if.slave bus
);
  localparam int REC_BYTES = 120;
  localparam int REC_W     = REC_BYTES * 8;
  localparam int LANE_W    = LANE_BYTES * 8;
  localparam int LANE_LOG2 = $clog2(LANE_BYTES);

  // First member sits at the MSB, so byte 0 of the stream is the top byte.
  typedef struct packed {
    logic [15:0]  block_size;
    logic [31:0]  seq_number;
    logic [7:0]   message_number;
    logic [63:0]  time_message;
    logic [279:0] msg_1;
    logic [279:0] msg_2;
    logic [279:0] msg_3;
  } rec_t;

  typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;

  state_t            state;
  logic [REC_W-1:0]  rec_q;      // shifted up by one lane per SUM cycle
  logic [CSUM_W-1:0] acc;
  logic [6:0]        lane;
  logic [6:0]        last_lane;
  logic              err_q;
`ifdef STAGE2_CHECK_SUM_CMP_EN
  logic [CSUM_W-1:0] exp_q;
`endif

  logic [1:0]        m_eff;
  logic [6:0]        n_bytes;
  logic [7:0]        lanes_in;
  logic [6:0]        last_lane_in;
  rec_t              rec_in;

  // Clamp msg_cnt, zero the invalid messages up front and size the sweep.
  always_comb begin
    m_eff        = (bus.msg_cnt > 3'd3) ? 2'd3 : bus.msg_cnt[1:0];
    n_bytes      = 7'd15 + 7'd35 * {5'd0, m_eff};
    lanes_in     = ({1'b0, n_bytes} + 8'(LANE_BYTES - 1)) >> LANE_LOG2;
    last_lane_in = lanes_in[6:0] - 7'd1;
    rec_in.block_size     = bus.block_size_data;
    rec_in.seq_number     = bus.seq_number_data;
    rec_in.message_number = bus.message_number_data;
    rec_in.time_message   = bus.time_message_data;
    rec_in.msg_1          = (m_eff >= 2'd1) ? bus.message_1 : '0;
    rec_in.msg_2          = (m_eff >= 2'd2) ? bus.message_2 : '0;
    rec_in.msg_3          = (m_eff == 2'd3) ? bus.message_3 : '0;
  end

  logic [CSUM_W-1:0] lane_sum;
  logic [CSUM_W-1:0] acc_next;

  // Shared lane adder: zero-extended bytes at the top of rec_q, carries past CSUM_W dropped.
  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < LANE_BYTES; j++) begin
      lane_sum = lane_sum + CSUM_W'(rec_q[REC_W-1-8*j -: 8]);
    end
    acc_next = acc + lane_sum;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      rec_q              <= '0;
      acc                <= '0;
      lane               <= '0;
      last_lane          <= '0;
      err_q              <= 1'b0;
      bus.in_ready       <= 1'b1;
      bus.out_valid      <= 1'b0;
      bus.check_sum_data <= '0;
      bus.cnt_err        <= 1'b0;
`ifdef STAGE2_CHECK_SUM_CMP_EN
      exp_q              <= '0;
      bus.check_sum_ok   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            rec_q        <= rec_in;
            last_lane    <= last_lane_in;
            err_q        <= (bus.msg_cnt > 3'd3);
            acc          <= '0;
            lane         <= '0;
            bus.in_ready <= 1'b0;
            state        <= SUM;
`ifdef STAGE2_CHECK_SUM_CMP_EN
            exp_q        <= bus.exp_check_sum;
`endif
          end
        end
        SUM: begin
          acc   <= acc_next;
          rec_q <= rec_q << LANE_W;
          lane  <= lane + 7'd1;
          if (lane == last_lane) begin
            state              <= DONE;
            bus.out_valid      <= 1'b1;
            bus.check_sum_data <= acc_next;
            bus.cnt_err        <= err_q;
`ifdef STAGE2_CHECK_SUM_CMP_EN
            bus.check_sum_ok   <= (acc_next == exp_q);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage2_check_sum_ctrl.sv
// Directed bench for stage2_check_sum_ctrl (LANE_BYTES=8, CSUM_W=8).
// Each scenario task drives a record and checks latency, sum, flags and handshakes inline.
// Works with or without STAGE2_CHECK_SUM_CMP_EN.
module tb_stage2_check_sum_ctrl;
  localparam int CSUM_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [CSUM_W-1:0] expected_cs;

  always #5 clk = ~clk;

  stage2_check_sum_ctrl_if #(.CSUM_W(CSUM_W)) bus ();

  stage2_check_sum_ctrl #(.LANE_BYTES(8), .CSUM_W(CSUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Message bytes are uniform fills; expected_cs also feeds the compare port.
  task automatic load(input logic [15:0] bs, input logic [31:0] sq, input logic [7:0] mn,
                      input logic [63:0] tm, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [2:0] cnt);
    bus.block_size_data     = bs;
    bus.seq_number_data     = sq;
    bus.message_number_data = mn;
    bus.time_message_data   = tm;
    bus.message_1           = {35{b1}};
    bus.message_2           = {35{b2}};
    bus.message_3           = {35{b3}};
    bus.msg_cnt             = cnt;
`ifdef STAGE2_CHECK_SUM_CMP_EN
    bus.exp_check_sum       = expected_cs;
`endif
  endtask

  task automatic handshake();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Cycles after the capture cycle until out_valid; 40 means the bound expired.
  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.check_sum_data !== 8'h00) begin failures++; $display("FAIL rst_sum got=%h want=00", bus.check_sum_data); end
    checks++; if (bus.cnt_err !== 1'b0) begin failures++; $display("FAIL rst_cnt_err got=%b want=0", bus.cnt_err); end
`ifdef STAGE2_CHECK_SUM_CMP_EN
    checks++; if (bus.check_sum_ok !== 1'b0) begin failures++; $display("FAIL rst_ok got=%b want=0", bus.check_sum_ok); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_header_only();
    int n;
    expected_cs = 8'h0F;
    load(16'h0101, 32'h01010101, 8'h01, 64'h0101010101010101, 8'hFF, 8'hFF, 8'hFF, 3'd0);
    handshake();
    wait_out(n);
    checks++; if (n != 2) begin failures++; $display("FAIL hdr_latency got=%0d want=2", n); end
    checks++; if (bus.check_sum_data !== 8'h0F) begin failures++; $display("FAIL hdr_sum got=%h want=0f", bus.check_sum_data); end
    checks++; if (bus.cnt_err !== 1'b0) begin failures++; $display("FAIL hdr_cnt_err got=%b want=0", bus.cnt_err); end
`ifdef STAGE2_CHECK_SUM_CMP_EN
    checks++; if (bus.check_sum_ok !== 1'b1) begin failures++; $display("FAIL hdr_ok got=%b want=1", bus.check_sum_ok); end
`endif
    take_result();
  endtask

  task automatic test_full_load();
    int n;
    expected_cs = 8'h88;
    load(16'hFFFF, 32'hFFFFFFFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 3'd3);
    handshake();
    wait_out(n);
    checks++; if (n != 15) begin failures++; $display("FAIL full_latency got=%0d want=15", n); end
    checks++; if (bus.check_sum_data !== 8'h88) begin failures++; $display("FAIL full_sum got=%h want=88", bus.check_sum_data); end
    checks++; if (bus.cnt_err !== 1'b0) begin failures++; $display("FAIL full_cnt_err got=%b want=0", bus.cnt_err); end
`ifdef STAGE2_CHECK_SUM_CMP_EN
    checks++; if (bus.check_sum_ok !== 1'b1) begin failures++; $display("FAIL full_ok got=%b want=1", bus.check_sum_ok); end
`endif
    take_result();
  endtask

  task automatic test_masking();
    int n;
    // msg_cnt=1: 35 bytes of 0x02 = 70; message_2/3 0xFF must be masked.
    expected_cs = 8'h46;
    load(16'h0000, 32'h0, 8'h00, 64'h0, 8'h02, 8'hFF, 8'hFF, 3'd1);
    handshake();
    wait_out(n);
    checks++; if (n != 7) begin failures++; $display("FAIL mask1_latency got=%0d want=7", n); end
    checks++; if (bus.check_sum_data !== 8'h46) begin failures++; $display("FAIL mask1_sum got=%h want=46", bus.check_sum_data); end
    take_result();
    // msg_cnt=2: 35*1 + 35*3 = 140; message_3 masked.
    expected_cs = 8'h8C;
    load(16'h0000, 32'h0, 8'h00, 64'h0, 8'h01, 8'h03, 8'hFF, 3'd2);
    handshake();
    wait_out(n);
    checks++; if (n != 11) begin failures++; $display("FAIL mask2_latency got=%0d want=11", n); end
    checks++; if (bus.check_sum_data !== 8'h8C) begin failures++; $display("FAIL mask2_sum got=%h want=8c", bus.check_sum_data); end
    take_result();
    // Mixed header, msg_cnt=0: 70 + 824 + 128 + 36 = 1058 -> 0x22.
    expected_cs = 8'h22;
    load(16'h1234, 32'hDEADBEEF, 8'h80, 64'h0102030405060708, 8'hFF, 8'hFF, 8'hFF, 3'd0);
    handshake();
    wait_out(n);
    checks++; if (n != 2) begin failures++; $display("FAIL mixhdr_latency got=%0d want=2", n); end
    checks++; if (bus.check_sum_data !== 8'h22) begin failures++; $display("FAIL mixhdr_sum got=%h want=22", bus.check_sum_data); end
    take_result();
  endtask

  task automatic test_cnt_err();
    int n;
    expected_cs = 8'h88;
    load(16'hFFFF, 32'hFFFFFFFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 3'd5);
    handshake();
    wait_out(n);
    checks++; if (n != 15) begin failures++; $display("FAIL cerr_latency got=%0d want=15", n); end
    checks++; if (bus.check_sum_data !== 8'h88) begin failures++; $display("FAIL cerr_sum got=%h want=88", bus.check_sum_data); end
    checks++; if (bus.cnt_err !== 1'b1) begin failures++; $display("FAIL cerr_flag got=%b want=1", bus.cnt_err); end
    take_result();
    expected_cs = 8'h0F;
    load(16'h0101, 32'h01010101, 8'h01, 64'h0101010101010101, 8'h00, 8'h00, 8'h00, 3'd0);
    handshake();
    wait_out(n);
    checks++; if (bus.check_sum_data !== 8'h0F) begin failures++; $display("FAIL cerr_next_sum got=%h want=0f", bus.check_sum_data); end
    checks++; if (bus.cnt_err !== 1'b0) begin failures++; $display("FAIL cerr_next_flag got=%b want=0", bus.cnt_err); end
    take_result();
  endtask

  task automatic test_backpressure();
    int n;
    // Header 15 + 35*0x10 = 575 -> 0x3F.
    expected_cs = 8'h3F;
    load(16'h0101, 32'h01010101, 8'h01, 64'h0101010101010101, 8'h10, 8'h77, 8'h77, 3'd1);
    handshake();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_busy_in_ready got=%b want=0", bus.in_ready); end
    // Busy-time record offer must be ignored.
    load(16'hFFFF, 32'hFFFFFFFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 3'd3);
    bus.in_valid = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    wait_out(n);
    checks++; if (n != 5) begin failures++; $display("FAIL bp_latency got=%0d want=5", n); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, bus.out_valid); end
      checks++; if (bus.check_sum_data !== 8'h3F) begin failures++; $display("FAIL bp_hold_sum cyc=%0d got=%h want=3f", i, bus.check_sum_data); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b want=0", i, bus.in_ready); end
      step();
    end
    take_result();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b want=0", bus.out_valid); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid === 1'b1) n++;
    end
    checks++; if (n != 0) begin failures++; $display("FAIL bp_ghost_result got=%0d want=0", n); end
  endtask

  task automatic test_reset_mid_sum();
    int n;
    expected_cs = 8'h88;
    load(16'hFFFF, 32'hFFFFFFFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 3'd3);
    handshake();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rsum_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rsum_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.check_sum_data !== 8'h00) begin failures++; $display("FAIL rsum_sum got=%h want=00", bus.check_sum_data); end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid === 1'b1) n++;
    end
    checks++; if (n != 0) begin failures++; $display("FAIL rsum_aborted_result got=%0d want=0", n); end
    expected_cs = 8'h0F;
    load(16'h0101, 32'h01010101, 8'h01, 64'h0101010101010101, 8'hFF, 8'hFF, 8'hFF, 3'd0);
    handshake();
    wait_out(n);
    checks++; if (n != 2) begin failures++; $display("FAIL rsum_new_latency got=%0d want=2", n); end
    checks++; if (bus.check_sum_data !== 8'h0F) begin failures++; $display("FAIL rsum_new_sum got=%h want=0f", bus.check_sum_data); end
    take_result();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    expected_cs   = '0;
    load(16'h0, 32'h0, 8'h0, 64'h0, 8'h00, 8'h00, 8'h00, 3'd0);
    test_reset();
    test_header_only();
    test_full_load();
    test_masking();
    test_cnt_err();
    test_backpressure();
    test_reset_mid_sum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stage2_check_sum_ctrl.md
Name: stage2_check_sum_ctrl

Overview:
- Sequential checksum engine for stage 2. Accepts one captured packet record per transaction: block size, sequence number, message number, timestamp and up to three 280-bit messages.
- Computes the byte-sum checksum over the valid bytes using a single LANE_BYTES-wide adder shared across cycles, instead of a full combinational tree.
- Sits between the stage-2 field extractor (upstream) and the packet-check stage (downstream). Uses valid/ready handshakes on both sides.

Parameters:
- LANE_BYTES, 8, bytes summed per cycle; legal values 1, 2, 4, 8, 16.
- CSUM_W, 8, checksum width; the sum is taken modulo 2^CSUM_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input record valid
- in_ready  out  1  engine can accept a record
- block_size_data  in  16  block size field
- seq_number_data  in  32  sequence number
- message_number_data  in  8  message number field
- time_message_data  in  64  timestamp
- message_1, message_2, message_3  in  280 each  message payloads
- msg_cnt  in  3  number of valid messages (0..3)
- out_valid  out  1  checksum result valid
- out_ready  in  1  downstream accepts result
- check_sum_data  out  CSUM_W  checksum result
- cnt_err  out  1  msg_cnt was greater than 3 for this result

Behaviour:
- Reset values: in_ready=1, out_valid=0, check_sum_data=0, cnt_err=0, FSM state=IDLE, accumulator=0, lane index=0.
- Capture: when in_valid and in_ready are both high in IDLE, all fields and msg_cnt are registered. Inputs are don't-care afterwards.
- Byte stream, 120 bytes, byte 0 first:
  - block_size_data[15:8], then [7:0]
  - seq_number_data, MSB byte first
  - message_number_data
  - time_message_data, MSB byte first
  - message_1 bits [279:272] down to [7:0], then message_2, then message_3, same order
- Valid byte count: N = 15 + 35*m, where m = min(msg_cnt, 3). Bytes at index N or above are masked to zero.
- msg_cnt values 4..7 are treated as 3 and latch cnt_err=1 for this result.
- FSM states:
  - IDLE: in_ready=1. On a handshake, go to SUM with lane index=0 and accumulator=0.
  - SUM: in_ready=0. Each cycle, add the LANE_BYTES bytes at indices [lane*LANE_BYTES, +LANE_BYTES) to the accumulator, modulo 2^CSUM_W, with the zero mask applied. Increment lane. On the last lane, ceil(N/LANE_BYTES)-1, go to DONE.
  - DONE: out_valid=1 and check_sum_data=accumulator. On out_ready, go to IDLE.
- Width rule: each byte is zero-extended to CSUM_W bits before addition. All carries beyond CSUM_W are discarded. No end-around carry.
- Latency: handshake in cycle T, so out_valid rises in cycle T+1+ceil(N/LANE_BYTES). With LANE_BYTES=8, msg_cnt 0/1/2/3 gives 2/7/11/15 SUM cycles.
- Backpressure: while out_valid=1 and out_ready=0, check_sum_data and cnt_err hold stable and in_ready stays 0.
- After the output handshake, in_ready=1 in the next cycle. There is no overlap of input accept with DONE.
- in_valid while busy is ignored: no capture and no side effects.
- Reset mid-SUM or mid-DONE: the next cycle returns to reset values. The partial result is discarded and out_valid is never asserted for the aborted record.

Optional Feature:
- Macro: STAGE2_CHECK_SUM_CMP_EN.
- Defined: adds input exp_check_sum (CSUM_W bits), captured with the record, and output check_sum_ok (1 bit).
  - check_sum_ok = (accumulator == exp_check_sum). It is valid with out_valid and held under backpressure.
  - Reset value is 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Header-only timing: all header bytes 0x01, msg_cnt=0, handshake at T -> out_valid at T+3, check_sum_data=0x0F, cnt_err=0.
- Full load: all 120 bytes 0xFF, msg_cnt=3 -> out_valid at T+16, check_sum_data=0x88 (30600 mod 256).
- Masking: header 0x00, message_1 bytes 0x02, message_2 and message_3 bytes 0xFF, msg_cnt=1 -> check_sum_data=0x46 at T+8.
- Count error: same stimulus as full load but msg_cnt=5 -> check_sum_data=0x88, cnt_err=1. The next record with msg_cnt=0 gives cnt_err=0.
- Backpressure and busy input:
  - Hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0.
  - Pulse in_valid during SUM -> ignored.
  - After out_ready=1, in_ready=1 in the next cycle.
- Reset mid-SUM: assert rst at cycle T+4 of a msg_cnt=3 record -> next cycle in_ready=1 and out_valid=0. A new record's result equals its standalone checksum.
